fp_class_gen: RTL and testbench

- Inverse of the FP classifier: takes a one-hot 10-bit class request and produces an encoding of the requested format that falls in that class.
- Unconstrained fields (mantissa, exponent, NaN sign) are randomised by an internal LFSR.
- Used by the FPU self-test / operand-generation path. Outputs feed fp_class in the loopback check.

---
 rtl/fp_class_gen_pkg.sv | 67 ++++++
 rtl/fp_class_gen_lfsr.sv | 43 ++++
 rtl/fp_class_gen.sv | 200 ++++++++++++++++++++
 tb/tb_fp_class_gen.sv | 347 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fp_class_gen_pkg.sv
`default_nettype none
// ============================================================================
// Module  : fp_class_gen_pkg
// Brief   : Shared types, constants and helpers for the FP class generator:
//           format description, generator FSM states, LFSR taps and
//           canonical encodings.
// Revision: 1.0 - initial release
// ============================================================================
package fp_class_gen_pkg;

  typedef enum logic [1:0] {
    FP16 = 2'd0,
    FP32 = 2'd1,
    FP64 = 2'd2
  } fp_format_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DRAW = 2'd1,
    DONE = 2'd2
  } gen_state_e;

  // Class mask width; bit n matches the fp_class output encoding.
  localparam int CLASS_W = 10;

  // Galois feedback mask for x^64 + x^63 + x^61 + x^60 + 1 (right-shifting form).
  localparam logic [63:0] LFSR64_TAPS = 64'hD800_0000_0000_0000;

  function automatic int exp_bits(input fp_format_e fmt);
    case (fmt)
      FP16:    return 5;
      FP64:    return 11;
      default: return 8;
    endcase
  endfunction

  function automatic int man_bits(input fp_format_e fmt);
    case (fmt)
      FP16:    return 10;
      FP64:    return 52;
      default: return 23;
    endcase
  endfunction

  function automatic int fp_width(input fp_format_e fmt);
    return 1 + exp_bits(fmt) + man_bits(fmt);
  endfunction

  // Sign 0, exponent all-ones, only the mantissa MSB set; right-aligned in 64 bits.
  function automatic logic [63:0] canonical_qnan(input fp_format_e fmt);
    logic [63:0] r;
    r = ((64'd1 << exp_bits(fmt)) - 64'd1) << man_bits(fmt);
    r = r | (64'd1 << (man_bits(fmt) - 1));
    return r;
  endfunction

  // +1.0: exponent equal to the bias, mantissa zero; right-aligned in 64 bits.
  function automatic logic [63:0] one_encoding(input fp_format_e fmt);
    return ((64'd1 << (exp_bits(fmt) - 1)) - 64'd1) << man_bits(fmt);
  endfunction

  function automatic logic is_onehot10(input logic [CLASS_W-1:0] c);
    return (c != '0) && ((c & (c - 10'd1)) == '0);
  endfunction

endpackage : fp_class_gen_pkg
`default_nettype wire

// File: rtl/fp_class_gen_lfsr.sv
`default_nettype none
// ============================================================================
// Module  : fp_lfsr
// Brief   : Galois LFSR with seed load and single-step enable. An all-zero
//           seed (reset value or loaded) is replaced by 1 so the register can
//           never lock up.
// Revision: 1.0 - initial release
// ============================================================================
module fp_lfsr #(
  parameter int              WIDTH = 64,
  parameter logic [WIDTH-1:0] TAPS = '0,
  parameter logic [WIDTH-1:0] SEED = {{(WIDTH-1){1'b0}}, 1'b1}
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             seed_load_i,
  input  logic [WIDTH-1:0] seed_i,
  input  logic             step_i,
  output logic [WIDTH-1:0] state_o
);

  localparam logic [WIDTH-1:0] ONE     = {{(WIDTH-1){1'b0}}, 1'b1};
  localparam logic [WIDTH-1:0] RST_VAL = (SEED == '0) ? ONE : SEED;

  logic [WIDTH-1:0] lfsr_q;
  logic [WIDTH-1:0] seed_safe;

  assign seed_safe = (seed_i == '0) ? ONE : seed_i;
  assign state_o   = lfsr_q;

  // Seed load wins over stepping; each step shifts right and folds in the taps.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      lfsr_q <= RST_VAL;
    end else if (seed_load_i) begin
      lfsr_q <= seed_safe;
    end else if (step_i) begin
      lfsr_q <= {1'b0, lfsr_q[WIDTH-1:1]} ^ (lfsr_q[0] ? TAPS : '0);
    end
  end

endmodule : fp_lfsr
`default_nettype wire

// File: rtl/fp_class_gen.sv
`default_nettype none
// ============================================================================
// Module  : fp_class_gen
// Brief   : Produces an FP encoding belonging to a requested one-hot class.
//           Free fields come from an internal LFSR; draws that miss the class
//           are retried up to MAX_RETRY times before a fixed fallback is used.
// Revision: 1.0 - initial release
// ============================================================================
module fp_class_gen
  import fp_class_gen_pkg::*;
#(
  parameter fp_format_e  FP_FORMAT = FP32,
  parameter logic [63:0] SEED      = 64'h1,
  parameter int          MAX_RETRY = 8
) (
  input  logic                             clk_i,
  input  logic                             rst_i,
  input  logic                             start_i,
  input  logic [CLASS_W-1:0]               class_i,
  input  logic                             seed_load_i,
  input  logic [63:0]                      seed_i,
  output logic                             busy_o,
  output logic                             done_o,
  output logic                             err_o,
  output logic [fp_width(FP_FORMAT)-1:0]   value_o
);

  localparam int EXP_W    = exp_bits(FP_FORMAT);
  localparam int MAN_W    = man_bits(FP_FORMAT);
  localparam int FP_WIDTH = fp_width(FP_FORMAT);
  localparam int RETRY_W  = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;

  localparam logic [RETRY_W-1:0] RETRY_LAST = RETRY_W'(MAX_RETRY);
  localparam logic [63:0]        QNAN64     = canonical_qnan(FP_FORMAT);
  localparam logic [EXP_W-1:0]   EXP_ONES   = '1;
  localparam logic [EXP_W-1:0]   EXP_BIAS   = {1'b0, {(EXP_W-1){1'b1}}};

  gen_state_e              state_q, state_d;
  logic [CLASS_W-1:0]      cls_q;
  logic                    bad_q;
  logic [RETRY_W-1:0]      retry_q;
  logic [FP_WIDTH-1:0]     value_q;
  logic                    err_q;
  logic [63:0]             lfsr;

  logic                    lfsr_step;
  logic                    lfsr_load;
  logic                    req_take;
  logic                    retry_inc;
  logic                    value_load;
  logic [FP_WIDTH-1:0]     value_d;
  logic                    err_d;

  logic [MAN_W-1:0]        mant_draw;
  logic [EXP_W-1:0]        exp_draw;
  logic                    rsign;
  logic                    cand_sign;
  logic [EXP_W-1:0]        cand_exp;
  logic [MAN_W-1:0]        cand_mant;
  logic [EXP_W-1:0]        fb_exp;
  logic [MAN_W-1:0]        fb_mant;
  logic                    reject;

  // Seeds are only accepted while idle so a draw in flight is never disturbed.
  assign lfsr_load = (state_q == IDLE) && seed_load_i;

  fp_lfsr #(
    .WIDTH (64),
    .TAPS  (LFSR64_TAPS),
    .SEED  (SEED)
  ) u_lfsr (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .seed_load_i (lfsr_load),
    .seed_i      (seed_i),
    .step_i      (lfsr_step),
    .state_o     (lfsr)
  );

  assign mant_draw = lfsr[MAN_W-1:0];
  assign exp_draw  = lfsr[MAN_W+EXP_W-1:MAN_W];
  assign rsign     = lfsr[63];

  // Candidate, acceptance test and fallback for the latched class.
  always_comb begin
    cand_sign = |cls_q[3:0];
    cand_exp  = '0;
    cand_mant = '0;
    fb_exp    = '0;
    fb_mant   = '0;
    reject    = 1'b0;
    if (cls_q[0] || cls_q[7]) begin
      cand_exp = EXP_ONES;
    end else if (cls_q[1] || cls_q[6]) begin
      cand_exp  = exp_draw;
      cand_mant = mant_draw;
      reject    = (exp_draw == '0) || (exp_draw == EXP_ONES);
      fb_exp    = EXP_BIAS;
    end else if (cls_q[2] || cls_q[5]) begin
      cand_mant = mant_draw;
      reject    = (mant_draw == '0);
      fb_mant   = MAN_W'(1);
    end else if (cls_q[8]) begin
      cand_sign = rsign;
      cand_exp  = EXP_ONES;
      cand_mant = {1'b0, mant_draw[MAN_W-2:0]};
      reject    = (mant_draw[MAN_W-2:0] == '0);
      fb_exp    = EXP_ONES;
      fb_mant   = MAN_W'(1);
    end else if (cls_q[9]) begin
      cand_sign = rsign;
      cand_exp  = EXP_ONES;
      cand_mant = {1'b1, mant_draw[MAN_W-2:0]};
    end
  end

  // State register.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state and datapath controls. A malformed request still spends one
  // DRAW cycle so its response arrives with the same timing as the fastest
  // valid one.
  always_comb begin
    state_d    = state_q;
    lfsr_step  = 1'b0;
    req_take   = 1'b0;
    retry_inc  = 1'b0;
    value_load = 1'b0;
    value_d    = {cand_sign, cand_exp, cand_mant};
    err_d      = 1'b0;
    case (state_q)
      IDLE: begin
        if (!seed_load_i && start_i) begin
          req_take = 1'b1;
          state_d  = DRAW;
        end
      end
      DRAW: begin
        lfsr_step = 1'b1;
        if (bad_q) begin
          value_load = 1'b1;
          value_d    = QNAN64[FP_WIDTH-1:0];
          err_d      = 1'b1;
          state_d    = DONE;
        end else if (!reject) begin
          value_load = 1'b1;
          state_d    = DONE;
        end else if (retry_q == RETRY_LAST) begin
          value_load = 1'b1;
          value_d    = {cand_sign, fb_exp, fb_mant};
          state_d    = DONE;
        end else begin
          retry_inc = 1'b1;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Request latch, retry counter and result register.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cls_q   <= '0;
      bad_q   <= 1'b0;
      retry_q <= '0;
      value_q <= '0;
      err_q   <= 1'b0;
    end else begin
      if (req_take) begin
        cls_q   <= class_i;
        bad_q   <= !is_onehot10(class_i);
        retry_q <= '0;
      end else if (retry_inc) begin
        retry_q <= retry_q + RETRY_W'(1);
      end
      if (value_load) begin
        value_q <= value_d;
        err_q   <= err_d;
      end
    end
  end

  assign busy_o  = (state_q == DRAW);
  assign done_o  = (state_q == DONE);
  assign err_o   = done_o && err_q;
  assign value_o = value_q;

endmodule : fp_class_gen
`default_nettype wire

// File: tb/tb_fp_class_gen.sv
`default_nettype none
// ============================================================================
// Module  : tb_fp_class_gen
// Brief   : Self-checking bench for fp_class_gen. Three instances (FP32 with
//           retries, FP32 without retries, FP16 with retries) share stimulus;
//           a reference model predicts each result into a per-instance queue
//           that is drained whenever done_o fires.
// Revision: 1.0 - initial release
// ============================================================================
module tb_fp_class_gen;
  import fp_class_gen_pkg::*;

  localparam int EW [3] = '{8, 8, 5};
  localparam int MW [3] = '{23, 23, 10};
  localparam int MR [3] = '{8, 0, 8};

  typedef struct {
    logic [63:0] v;
    logic        e;
    int          lat;
    int          sc;
    logic [9:0]  c;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        seed_load;
  logic [9:0]  cls;
  logic [63:0] seed;
  logic [2:0]  busy, done, err;
  logic [31:0] va, vb;
  logic [15:0] vc;
  logic [63:0] vout [3];

  int          total = 0;
  int          bad   = 0;
  int          cyc   = 0;
  logic [63:0] lm [3];
  logic [63:0] last_v [3];
  logic        last_e [3];
  exp_t        q0[$], q1[$], q2[$];
  exp_t        mx;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  assign vout[0] = {32'h0, va};
  assign vout[1] = {32'h0, vb};
  assign vout[2] = {48'h0, vc};

  fp_class_gen #(.FP_FORMAT(FP32), .SEED(64'h1), .MAX_RETRY(8)) u_dut_a (
    .clk_i(clk), .rst_i(rst), .start_i(start), .class_i(cls),
    .seed_load_i(seed_load), .seed_i(seed),
    .busy_o(busy[0]), .done_o(done[0]), .err_o(err[0]), .value_o(va));

  fp_class_gen #(.FP_FORMAT(FP32), .SEED(64'h1), .MAX_RETRY(0)) u_dut_b (
    .clk_i(clk), .rst_i(rst), .start_i(start), .class_i(cls),
    .seed_load_i(seed_load), .seed_i(seed),
    .busy_o(busy[1]), .done_o(done[1]), .err_o(err[1]), .value_o(vb));

  fp_class_gen #(.FP_FORMAT(FP16), .SEED(64'h1), .MAX_RETRY(8)) u_dut_c (
    .clk_i(clk), .rst_i(rst), .start_i(start), .class_i(cls),
    .seed_load_i(seed_load), .seed_i(seed),
    .busy_o(busy[2]), .done_o(done[2]), .err_o(err[2]), .value_o(vc));

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got=%h want=%h (t=%0t)", tag, got, want, $time);
    end
  endtask

  function automatic logic [63:0] lfsr_next(input logic [63:0] s);
    logic [63:0] n;
    n = s >> 1;
    if (s[0]) begin
      n[63] = ~n[63];
      n[62] = ~n[62];
      n[60] = ~n[60];
      n[59] = ~n[59];
    end
    return n;
  endfunction

  function automatic logic [63:0] enc(input bit sg, input logic [63:0] e,
                                      input logic [63:0] m, input int ew, input int mw);
    return (64'(sg) << (ew + mw)) | (e << mw) | m;
  endfunction

  function automatic logic [9:0] classify(input logic [63:0] v, input int ew, input int mw);
    logic [63:0] e, m, ones;
    bit          sg;
    ones = (64'd1 << ew) - 64'd1;
    sg   = v[ew + mw];
    e    = (v >> mw) & ones;
    m    = v & ((64'd1 << mw) - 64'd1);
    if (e == ones) begin
      if (m == 0)                    return sg ? 10'h001 : 10'h080;
      else if (((m >> (mw - 1)) & 64'd1) != 0) return 10'h200;
      else                           return 10'h100;
    end else if (e == 0) begin
      if (m == 0) return sg ? 10'h008 : 10'h010;
      else        return sg ? 10'h004 : 10'h020;
    end
    return sg ? 10'h002 : 10'h040;
  endfunction

  // Reference model: consumes draws from the instance's model LFSR.
  function automatic exp_t predict(input int k, input logic [9:0] c, input int sc);
    exp_t        r;
    int          ew, mw, tries, b;
    logic [63:0] ones, s, m, x, low;
    bit          ok, sg;
    ew = EW[k];
    mw = MW[k];
    ones = (64'd1 << ew) - 64'd1;
    r.sc = sc;
    r.c  = c;
    r.e  = 1'b0;
    if ($countones(c) != 1) begin
      lm[k] = lfsr_next(lm[k]);
      r.v   = (ones << mw) | (64'd1 << (mw - 1));
      r.e   = 1'b1;
      r.lat = 2;
      return r;
    end
    b = 0;
    for (int i = 0; i < 10; i++) if (c[i]) b = i;
    sg = (b <= 3);
    tries = 0;
    while (1) begin
      s     = lm[k];
      lm[k] = lfsr_next(s);
      m     = s & ((64'd1 << mw) - 64'd1);
      x     = (s >> mw) & ones;
      low   = m & ((64'd1 << (mw - 1)) - 64'd1);
      ok    = 1'b1;
      case (b)
        0, 7: r.v = enc(sg, ones, 0, ew, mw);
        1, 6: begin
          ok  = (x != 0) && (x != ones);
          r.v = ok ? enc(sg, x, m, ew, mw) : enc(sg, ones >> 1, 0, ew, mw);
        end
        2, 5: begin
          ok  = (m != 0);
          r.v = enc(sg, 0, ok ? m : 64'd1, ew, mw);
        end
        3, 4: r.v = enc(sg, 0, 0, ew, mw);
        8: begin
          ok  = (low != 0);
          r.v = enc(s[63], ones, ok ? low : 64'd1, ew, mw);
        end
        default: r.v = enc(s[63], ones, (64'd1 << (mw - 1)) | low, ew, mw);
      endcase
      if (ok || tries == MR[k]) break;
      tries++;
    end
    r.lat = tries + 2;
    return r;
  endfunction

  function automatic int qsize(input int k);
    case (k)
      0:       return q0.size();
      1:       return q1.size();
      default: return q2.size();
    endcase
  endfunction

  function automatic void qpush(input int k, input exp_t x);
    case (k)
      0:       q0.push_back(x);
      1:       q1.push_back(x);
      default: q2.push_back(x);
    endcase
  endfunction

  function automatic exp_t qpop(input int k);
    case (k)
      0:       return q0.pop_front();
      1:       return q1.pop_front();
      default: return q2.pop_front();
    endcase
  endfunction

  // Output monitor: every done_o must match the oldest prediction.
  always @(negedge clk) begin
    for (int k = 0; k < 3; k++) begin
      if (done[k]) begin
        if (qsize(k) == 0) begin
          chk($sformatf("unexpected_done%0d", k), 64'd1, 64'd0);
        end else begin
          mx = qpop(k);
          last_v[k] = vout[k];
          last_e[k] = err[k];
          chk($sformatf("value%0d", k), vout[k], mx.v);
          chk($sformatf("err%0d", k), 64'(err[k]), 64'(mx.e));
          chk($sformatf("latency%0d", k), 64'(cyc - mx.sc + 1), 64'(mx.lat));
          chk($sformatf("lat_range%0d", k),
              64'((cyc - mx.sc + 1) >= 2 && (cyc - mx.sc + 1) <= 2 + MR[k]), 64'd1);
          if (!mx.e) chk($sformatf("class%0d", k), 64'(classify(vout[k], EW[k], MW[k])), 64'(mx.c));
        end
      end else if (err[k]) begin
        chk($sformatf("err_without_done%0d", k), 64'd1, 64'd0);
      end
    end
  end

  task automatic wait_idle();
    int n;
    n = 0;
    while ((q0.size() + q1.size() + q2.size()) != 0 && n < 40) begin
      @(posedge clk);
      n++;
    end
    if ((q0.size() + q1.size() + q2.size()) != 0) begin
      chk("done_timeout", 64'd0, 64'd1);
      q0.delete();
      q1.delete();
      q2.delete();
    end
  endtask

  // Seed load with start raised alongside: the load must win and start be dropped.
  task automatic do_seed(input logic [63:0] s);
    @(negedge clk);
    seed_load = 1'b1;
    seed      = s;
    start     = 1'b1;
    cls       = 10'h080;
    @(posedge clk);
    #1;
    seed_load = 1'b0;
    start     = 1'b0;
    for (int k = 0; k < 3; k++) lm[k] = (s == 64'd0) ? 64'd1 : s;
  endtask

  task automatic req(input logic [9:0] c, input bit poke);
    @(negedge clk);
    start = 1'b1;
    cls   = c;
    @(posedge clk);
    #1;
    start = 1'b0;
    for (int k = 0; k < 3; k++) qpush(k, predict(k, c, cyc));
    if (poke) begin
      chk("busy_during_draw", 64'(busy), 64'h7);
      seed_load = 1'b1;
      seed      = 64'hDEAD_BEEF_1234_5678;
      start     = 1'b1;
      cls       = 10'h001;
      @(posedge clk);
      #1;
      seed_load = 1'b0;
      start     = 1'b0;
    end
    wait_idle();
  endtask

  initial begin
    rst       = 1'b1;
    start     = 1'b0;
    seed_load = 1'b0;
    cls       = '0;
    seed      = '0;
    for (int k = 0; k < 3; k++) begin
      lm[k]     = 64'd1;
      last_v[k] = '0;
      last_e[k] = 1'b0;
    end
    repeat (3) @(posedge clk);
    #1;
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("rst_busy%0d", k), 64'(busy[k]), 64'd0);
      chk($sformatf("rst_done%0d", k), 64'(done[k]), 64'd0);
      chk($sformatf("rst_err%0d", k), 64'(err[k]), 64'd0);
      chk($sformatf("rst_value%0d", k), vout[k], 64'd0);
    end
    @(negedge clk);
    rst = 1'b0;

    req(10'h080, 1'b0);
    chk("pos_inf32", last_v[0], 64'h7F80_0000);
    chk("pos_inf16", last_v[2], 64'h7C00);
    req(10'h008, 1'b0);
    chk("neg_zero32", last_v[0], 64'h8000_0000);
    req(10'h010, 1'b0);
    chk("pos_zero32", last_v[0], 64'h0000_0000);

    do_seed(64'h1);
    req(10'h040, 1'b0);
    chk("fallback_pos_one", last_v[1], 64'h3F80_0000);
    do_seed(64'h1);
    req(10'h002, 1'b0);
    chk("fallback_neg_one", last_v[1], 64'hBF80_0000);

    req(10'h003, 1'b0);
    chk("bad_class_qnan", last_v[0], 64'h7FC0_0000);
    chk("bad_class_err", 64'(last_e[0]), 64'd1);
    req(10'h000, 1'b0);
    chk("zero_class_qnan", last_v[0], 64'h7FC0_0000);
    chk("zero_class_qnan16", last_v[2], 64'h7E00);
    chk("zero_class_err", 64'(last_e[0]), 64'd1);

    // Start and seed pulses while busy must leave the model in step.
    req(10'h200, 1'b1);
    req(10'h100, 1'b1);
    req(10'h040, 1'b0);

    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(0, 3) == 0)
        do_seed((i % 40 == 0) ? 64'd0 : {$urandom, $urandom});
      req(10'(1) << $urandom_range(0, 9), 1'b0);
    end

    // Reset in the middle of a draw: outputs clear at once, nothing completes.
    req(10'h080, 1'b0);
    @(negedge clk);
    start = 1'b1;
    cls   = 10'h040;
    @(posedge clk);
    #1;
    start = 1'b0;
    chk("busy_before_reset", 64'(busy), 64'h7);
    #2;
    rst = 1'b1;
    #1;
    chk("async_rst_busy", 64'(busy), 64'd0);
    chk("async_rst_done", 64'(done), 64'd0);
    chk("async_rst_value32", vout[0], 64'd0);
    chk("async_rst_value16", vout[2], 64'd0);
    for (int k = 0; k < 3; k++) lm[k] = 64'd1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    repeat (6) @(posedge clk);
    req(10'h020, 1'b0);
    req(10'h040, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_fp_class_gen
`default_nettype wire
